// File: rtl/bsg_mem_bist_pkg.sv
// Shared types for the March C- memory BIST: element table, op kind, FSM states.
package bsg_mem_bist_pkg;

    typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} march_elem_e;
    typedef enum logic {OP_READ, OP_WRITE} op_e;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    typedef struct packed {
        logic       down;
        logic [1:0] nops;
        op_e        first_op;
        logic       rd_pol;
        logic       wr_pol;
    } elem_cfg_s;

    // A two-op element is always read-then-write; single-op elements are M0 (w0) and M5 (r0).
    function automatic elem_cfg_s elem_cfg(input march_elem_e e);
        unique case (e)
            M0:      elem_cfg = '{down: 1'b0, nops: 2'd1, first_op: OP_WRITE, rd_pol: 1'b0, wr_pol: 1'b0};
            M1:      elem_cfg = '{down: 1'b0, nops: 2'd2, first_op: OP_READ,  rd_pol: 1'b0, wr_pol: 1'b1};
            M2:      elem_cfg = '{down: 1'b0, nops: 2'd2, first_op: OP_READ,  rd_pol: 1'b1, wr_pol: 1'b0};
            M3:      elem_cfg = '{down: 1'b1, nops: 2'd2, first_op: OP_READ,  rd_pol: 1'b0, wr_pol: 1'b1};
            M4:      elem_cfg = '{down: 1'b1, nops: 2'd2, first_op: OP_READ,  rd_pol: 1'b1, wr_pol: 1'b0};
            default: elem_cfg = '{down: 1'b0, nops: 2'd1, first_op: OP_READ,  rd_pol: 1'b0, wr_pol: 1'b0};
        endcase
    endfunction

endpackage

// File: rtl/bsg_mem_bist_addr_gen.sv
// Up/down address counter over 0..els_p-1 with per-direction load and last-address flag.
module bsg_mem_bist_addr_gen #(
    parameter int els_p        = 16,
    parameter int addr_width_p = (els_p == 1) ? 1 : $clog2(els_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    load_i,
    input  logic                    load_down_i,
    input  logic                    step_i,
    input  logic                    down_i,
    output logic [addr_width_p-1:0] addr_o,
    output logic                    last_o
);

    localparam logic [addr_width_p-1:0] max_lp = addr_width_p'(els_p - 1);

    logic [addr_width_p-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load_i)
            addr_d = load_down_i ? max_lp : '0;
        else if (step_i)
            addr_d = down_i ? addr_q - addr_width_p'(1) : addr_q + addr_width_p'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) addr_q <= '0;
        else            addr_q <= addr_d;
    end

    assign addr_o = addr_q;
    assign last_o = down_i ? (addr_q == '0) : (addr_q == max_lp);

endmodule

// File: rtl/bsg_mem_1rw_sync_bist.sv
// March C- BIST engine for one bsg_mem_1rw_sync port, with first-fail capture and fail counting.
module bsg_mem_1rw_sync_bist
    import bsg_mem_bist_pkg::*;
#(
    parameter int width_p            = 8,
    parameter int els_p              = 16,
    parameter int addr_width_p       = (els_p == 1) ? 1 : $clog2(els_p),
    parameter int num_backgrounds_p  = 1,
    parameter int fail_count_width_p = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          pass_o,
    output logic [addr_width_p-1:0]       fail_addr_o,
    output logic [2:0]                    fail_elem_o,
    output logic                          fail_bg_o,
    output logic [width_p-1:0]            fail_expected_o,
    output logic [width_p-1:0]            fail_actual_o,
    output logic [fail_count_width_p-1:0] fail_count_o,
    output logic                          mem_v_o,
    output logic                          mem_w_o,
    output logic [addr_width_p-1:0]       mem_addr_o,
    output logic [width_p-1:0]            mem_data_o,
    input  logic [width_p-1:0]            mem_data_i
);

    state_e      state_q, state_d;
    march_elem_e elem_q, elem_d;
    logic        bg_q, bg_d, phase_q, phase_d;
    elem_cfg_s   cfg, nxt_cfg;

    logic                    addr_load, addr_load_down, addr_step, addr_last;
    logic [addr_width_p-1:0] addr;
    logic                    run, start_ok, op_is_read, op_last, run_last;
    logic [width_p-1:0]      pat, rd_exp, wr_data;

    logic                          rd_v_q;
    logic [width_p-1:0]            rd_exp_q;
    logic [addr_width_p-1:0]       rd_addr_q;
    logic [2:0]                    rd_elem_q;
    logic                          rd_bg_q;
    logic                          miscmp;
    logic [addr_width_p-1:0]       f_addr_q;
    logic [2:0]                    f_elem_q;
    logic                          f_bg_q;
    logic [width_p-1:0]            f_exp_q, f_act_q;
    logic [fail_count_width_p-1:0] f_cnt_q;

    // Background 1 "0" pattern: alternating bits with bit0=1, inverted on odd addresses.
    function automatic logic [width_p-1:0] pat0(input logic bg, input logic a0);
        logic [width_p-1:0] r;
        for (int i = 0; i < width_p; i++) r[i] = bg & (a0 ^ ~i[0]);
        return r;
    endfunction

    assign cfg        = elem_cfg(elem_q);
    assign run        = (state_q == S_RUN);
    assign start_ok   = start_i && (state_q == S_IDLE || state_q == S_DONE);
    assign op_is_read = !phase_q && (cfg.first_op == OP_READ);
    assign op_last    = phase_q == (cfg.nops == 2'd2);
    assign run_last   = op_last && addr_last && (elem_q == M5) && (bg_q == 1'(num_backgrounds_p - 1));
    assign pat        = pat0(bg_q, addr[0]);
    assign rd_exp     = pat ^ {width_p{cfg.rd_pol}};
    assign wr_data    = pat ^ {width_p{cfg.wr_pol}};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_ok) state_d = S_RUN;
            S_RUN:   if (run_last) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            default: if (start_ok) state_d = S_RUN;
        endcase
    end

    always_comb begin
        busy_o     = (state_q == S_RUN) || (state_q == S_DRAIN);
        done_o     = (state_q == S_DONE);
        pass_o     = (state_q == S_DONE) && (f_cnt_q == '0);
        mem_v_o    = run;
        mem_w_o    = run && !op_is_read;
        mem_addr_o = run ? addr : '0;
        mem_data_o = (run && !op_is_read) ? wr_data : '0;
    end

    // Sequencer: the address load on an element change lands on the next element's first address.
    always_comb begin
        elem_d         = elem_q;
        bg_d           = bg_q;
        phase_d        = phase_q;
        nxt_cfg        = cfg;
        addr_load      = 1'b0;
        addr_load_down = 1'b0;
        addr_step      = 1'b0;
        if (start_ok) begin
            elem_d    = M0;
            bg_d      = 1'b0;
            phase_d   = 1'b0;
            addr_load = 1'b1;
        end else if (run) begin
            if (!op_last) begin
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                if (!addr_last) begin
                    addr_step = 1'b1;
                end else begin
                    addr_load = 1'b1;
                    if (elem_q == M5) begin
                        elem_d = M0;
                        bg_d   = ~bg_q & (num_backgrounds_p == 2);
                    end else begin
                        elem_d = march_elem_e'(elem_q + 3'd1);
                    end
                    nxt_cfg        = elem_cfg(elem_d);
                    addr_load_down = nxt_cfg.down;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            elem_q  <= M0;
            bg_q    <= 1'b0;
            phase_q <= 1'b0;
        end else begin
            elem_q  <= elem_d;
            bg_q    <= bg_d;
            phase_q <= phase_d;
        end
    end

    bsg_mem_bist_addr_gen #(
        .els_p        (els_p),
        .addr_width_p (addr_width_p)
    ) u_addr_gen (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .load_i      (addr_load),
        .load_down_i (addr_load_down),
        .step_i      (addr_step),
        .down_i      (cfg.down),
        .addr_o      (addr),
        .last_o      (addr_last)
    );

    assign miscmp = rd_v_q && (mem_data_i != rd_exp_q);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_v_q    <= 1'b0;
            rd_exp_q  <= '0;
            rd_addr_q <= '0;
            rd_elem_q <= '0;
            rd_bg_q   <= 1'b0;
            f_addr_q  <= '0;
            f_elem_q  <= '0;
            f_bg_q    <= 1'b0;
            f_exp_q   <= '0;
            f_act_q   <= '0;
            f_cnt_q   <= '0;
        end else begin
            rd_v_q <= run && op_is_read;
            if (run && op_is_read) begin
                rd_exp_q  <= rd_exp;
                rd_addr_q <= addr;
                rd_elem_q <= elem_q;
                rd_bg_q   <= bg_q;
            end
            if (start_ok) begin
                f_addr_q <= '0;
                f_elem_q <= '0;
                f_bg_q   <= 1'b0;
                f_exp_q  <= '0;
                f_act_q  <= '0;
                f_cnt_q  <= '0;
            end else if (miscmp) begin
                if (f_cnt_q == '0) begin
                    f_addr_q <= rd_addr_q;
                    f_elem_q <= rd_elem_q;
                    f_bg_q   <= rd_bg_q;
                    f_exp_q  <= rd_exp_q;
                    f_act_q  <= mem_data_i;
                end
                if (~&f_cnt_q) f_cnt_q <= f_cnt_q + fail_count_width_p'(1);
            end
        end
    end

    assign fail_addr_o     = f_addr_q;
    assign fail_elem_o     = f_elem_q;
    assign fail_bg_o       = f_bg_q;
    assign fail_expected_o = f_exp_q;
    assign fail_actual_o   = f_act_q;
    assign fail_count_o    = f_cnt_q;

endmodule

// File: tb/tb_bsg_mem_1rw_sync_bist.sv
// Bench: BIST driving a behavioural sync 1rw memory with injectable stuck-at bits, checked against a march model.
module tb_bsg_mem_1rw_sync_bist;

    localparam int W   = 4;
    localparam int ELS = 5;
    localparam int AW  = 3;
    localparam int NBG = 2;
    localparam int FCW = 3;
    localparam int N   = 10 * ELS * NBG;

    logic clk = 0, rst_n = 0, start = 0;
    logic busy, done, pass, fbg, mv, mw;
    logic [AW-1:0] faddr, maddr;
    logic [2:0] felem;
    logic [W-1:0] fexp, fact, mdo, mdi;
    logic [FCW-1:0] fcnt;

    always #5 clk = ~clk;

    bsg_mem_1rw_sync_bist #(
        .width_p(W), .els_p(ELS), .addr_width_p(AW),
        .num_backgrounds_p(NBG), .fail_count_width_p(FCW)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start),
        .busy_o(busy), .done_o(done), .pass_o(pass),
        .fail_addr_o(faddr), .fail_elem_o(felem), .fail_bg_o(fbg),
        .fail_expected_o(fexp), .fail_actual_o(fact), .fail_count_o(fcnt),
        .mem_v_o(mv), .mem_w_o(mw), .mem_addr_o(maddr), .mem_data_o(mdo),
        .mem_data_i(mdi)
    );

    // Memory under test with per-address stuck-at masks
    logic [W-1:0] mem [ELS];
    logic [W-1:0] sa_mask [ELS];
    logic [W-1:0] sa_val [ELS];

    function automatic logic [W-1:0] faulty(input logic [W-1:0] d, input int a);
        return (d & ~sa_mask[a]) | (sa_val[a] & sa_mask[a]);
    endfunction

    always @(posedge clk) begin
        if (mv && int'(maddr) < ELS) begin
            if (mw) mem[int'(maddr)] <= faulty(mdo, int'(maddr));
            else    mdi <= faulty(mem[int'(maddr)], int'(maddr));
        end
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Reference model: walk the march algorithm over an array.
    typedef struct packed {logic w; logic [AW-1:0] a; logic [W-1:0] d;} op_t;
    op_t exp_ops[$];
    int exp_cnt;
    logic [AW+3+1+2*W-1:0] exp_cap;
    string el_str[6] = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};

    function automatic logic [W-1:0] pattern(input int bg, input int a, input int pol);
        int v = 0;
        if (bg == 1)
            for (int i = 0; i < W; i++)
                if (((i % 2) == 0) != ((a % 2) == 1)) v += (1 << i);
        if (pol != 0) v = (1 << W) - 1 - v;
        return W'(v);
    endfunction

    task automatic build_model();
        logic [W-1:0] mv_arr [ELS];
        logic [W-1:0] x;
        int a;
        exp_ops.delete();
        exp_cnt = 0;
        exp_cap = '0;
        for (int i = 0; i < ELS; i++) mv_arr[i] = '0;
        for (int bg = 0; bg < NBG; bg++)
            for (int e = 0; e < 6; e++)
                for (int k = 0; k < ELS; k++) begin
                    a = (e == 3 || e == 4) ? ELS - 1 - k : k;
                    for (int j = 0; j < el_str[e].len(); j += 2) begin
                        x = pattern(bg, a, (el_str[e][j+1] == "1") ? 1 : 0);
                        if (el_str[e][j] == "w") begin
                            exp_ops.push_back('{w: 1'b1, a: AW'(a), d: x});
                            mv_arr[a] = faulty(x, a);
                        end else begin
                            exp_ops.push_back('{w: 1'b0, a: AW'(a), d: '0});
                            if (mv_arr[a] != x) begin
                                if (exp_cnt == 0) exp_cap = {AW'(a), 3'(e), 1'(bg), x, mv_arr[a]};
                                if (exp_cnt < (1 << FCW) - 1) exp_cnt++;
                            end
                        end
                    end
                end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < ELS; i++) begin
            sa_mask[i] = '0;
            sa_val[i]  = '0;
        end
    endtask

    task automatic run_check(input string tag, input bit hold);
        build_model();
        @(negedge clk); start = 1;
        @(posedge clk); #1;
        if (!hold) start = 0;
        for (int j = 0; j < N; j++) begin
            chk({tag, "_op"}, {busy, done, mv, mw, maddr, (mw ? mdo : W'(0))},
                {1'b1, 1'b0, 1'b1, exp_ops[j]});
            @(posedge clk); #1;
        end
        chk({tag, "_drain"}, {busy, done, mv}, {1'b1, 1'b0, 1'b0});
        @(posedge clk); #1;
        chk({tag, "_done"}, {busy, done, pass}, {1'b0, 1'b1, 1'(exp_cnt == 0)});
        chk({tag, "_cnt"}, fcnt, exp_cnt);
        chk({tag, "_cap"}, {faddr, felem, fbg, fexp, fact}, exp_cap);
    endtask

    initial begin
        clear_faults();
        for (int i = 0; i < ELS; i++) mem[i] = W'($urandom);
        mdi = '0;
        #12;
        chk("reset", {busy, done, pass, faddr, felem, fbg, fexp, fact, fcnt, mv, mw, maddr, mdo}, '0);
        @(negedge clk); rst_n = 1;
        repeat (2) @(negedge clk);
        chk("idle", {busy, done, mv}, '0);

        run_check("clean", 0);

        // Stuck-at-1 on bit0 of address 2
        sa_mask[2] = 4'b0001; sa_val[2] = 4'b0001;
        run_check("sa1_a2", 0);

        for (int t = 0; t < 6; t++) begin
            int nf;
            clear_faults();
            nf = $urandom_range(1, 2);
            for (int f = 0; f < nf; f++) begin
                int a;
                a = $urandom_range(0, ELS - 1);
                sa_mask[a] = W'($urandom_range(1, (1 << W) - 1));
                sa_val[a]  = W'($urandom);
            end
            run_check("rnd", 0);
        end

        // Asynchronous abort mid-run, then a clean rerun
        clear_faults();
        @(negedge clk); start = 1;
        @(posedge clk); #1; start = 0;
        repeat (5) @(posedge clk);
        #3 rst_n = 0;
        #1 chk("abort", {busy, done, pass, faddr, felem, fbg, fexp, fact, fcnt, mv, mw, maddr, mdo}, '0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        run_check("after_abort", 0);

        // start held high: one run, then an immediate restart out of DONE
        run_check("hold", 1);
        @(posedge clk); #1;
        chk("restart", {busy, done, pass, mv, mw, maddr}, {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, AW'(0)});
        start = 0;
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
